branch_hazard_ctrl: RTL and testbench

Sequences branch resolution in the ID stage of the 5-stage MIPS pipeline. For every `beq`/`bne` in ID it:
- detects data hazards on `rs`/`rt` against EX and MEM;
- stalls IF/ID for the exact number of cycles needed;
- selects forwarded operands and drives the 32-bit equality comparator;
- produces the PC-select and IF/ID-flush decision.

It also keeps saturating taken-branch and stall-cycle counters for performance debug.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/branch_cmp.sv | 14 +
 rtl/branch_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline control blocks: branch FSM state
// encoding, the hard-wired zero register and the per-operand hazard rule.
package mips_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Cycles a branch source must wait before its value can be seen in ID:
    // a load in EX needs two, an ALU op in EX or a load in MEM needs one.
    function automatic logic [1:0] src_need(
        input logic [4:0] src,
        input logic       ex_wr_en,
        input logic       ex_is_load,
        input logic [4:0] ex_wr_reg,
        input logic       mem_wr_en,
        input logic       mem_is_load,
        input logic [4:0] mem_wr_reg
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = ex_wr_en  && (src != REG_ZERO) && (ex_wr_reg  == src);
        mem_hit = mem_wr_en && (src != REG_ZERO) && (mem_wr_reg == src);
        if (ex_hit && ex_is_load)
            return 2'd2;
        else if (ex_hit || (mem_hit && mem_is_load))
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// 32-bit equality comparator producing the beq/bne take decision.
module branch_cmp (
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        is_beq,
    output logic        take
);

    logic w_neq;

    assign w_neq = (op_a != op_b);
    assign take  = is_beq ? ~w_neq : w_neq;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch resolution: hazard-driven stall sequencing, operand
// forwarding from MEM, the taken/flush decision and saturating perf counters.
module branch_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_beq,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_target,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_wr_reg,
    input  logic             mem_wr_en,
    input  logic             mem_is_load,
    input  logic [4:0]       mem_wr_reg,
    input  logic [31:0]      mem_alu_result,
    input  logic             pipe_flush,
    output logic             stall,
    output logic             branch_taken,
    output logic             flush_ifid,
    output logic [31:0]      pc_target,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [1:0]       r_state;
    logic [1:0]       r_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [1:0]  w_state_next;
    logic [1:0]  w_cnt_next;
    logic        w_is_br;
    logic [1:0]  w_need_rs;
    logic [1:0]  w_need_rt;
    logic [1:0]  w_need;
    logic        w_fwd_rs;
    logic        w_fwd_rt;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic        w_take;
    logic        w_stall;
    logic        w_eval;

    assign w_is_br   = id_valid & id_is_branch;
    assign w_need_rs = src_need(id_rs, ex_wr_en, ex_is_load, ex_wr_reg,
                                mem_wr_en, mem_is_load, mem_wr_reg);
    assign w_need_rt = src_need(id_rt, ex_wr_en, ex_is_load, ex_wr_reg,
                                mem_wr_en, mem_is_load, mem_wr_reg);
    assign w_need    = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;

    // Only ALU results can be forwarded from MEM; load data arrives through
    // the write-before-read register file one cycle later.
    assign w_fwd_rs = mem_wr_en && !mem_is_load && (id_rs != REG_ZERO) && (mem_wr_reg == id_rs);
    assign w_fwd_rt = mem_wr_en && !mem_is_load && (id_rt != REG_ZERO) && (mem_wr_reg == id_rt);
    assign w_op_a   = w_fwd_rs ? mem_alu_result : id_rs_data;
    assign w_op_b   = w_fwd_rt ? mem_alu_result : id_rt_data;

    branch_cmp u_cmp (
        .op_a   (w_op_a),
        .op_b   (w_op_b),
        .is_beq (id_beq),
        .take   (w_take)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_eval       = 1'b0;
        if (pipe_flush) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_br) begin
                        if (w_need == 2'd0) begin
                            w_eval = 1'b1;
                        end else begin
                            w_stall      = 1'b1;
                            w_cnt_next   = w_need - 2'd1;
                            w_state_next = (w_need == 2'd1) ? ST_RESOLVE : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt - 2'd1;
                    if (r_cnt <= 2'd1)
                        w_state_next = ST_RESOLVE;
                end
                ST_RESOLVE: begin
                    w_eval       = 1'b1;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 2'd0;
                end
            endcase
        end
    end

    // Every output is forced low while reset is asserted.
    assign stall        = rst_n & w_stall;
    assign branch_taken = rst_n & w_eval & w_take;
    assign flush_ifid   = branch_taken;
    assign pc_target    = branch_taken ? id_target : 32'd0;
    assign taken_cnt    = rst_n ? r_taken_cnt : '0;
    assign stall_cnt    = rst_n ? r_stall_cnt : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_taken_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (branch_taken && (r_taken_cnt != '1))
                r_taken_cnt <= r_taken_cnt + 1'b1;
            if (stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed-vector bench for branch_hazard_ctrl with 4-bit perf counters so
// saturation is reachable in a short run.
module tb_branch_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic             id_is_branch;
    logic             id_beq;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [31:0]      id_rs_data;
    logic [31:0]      id_rt_data;
    logic [31:0]      id_target;
    logic             ex_wr_en;
    logic             ex_is_load;
    logic [4:0]       ex_wr_reg;
    logic             mem_wr_en;
    logic             mem_is_load;
    logic [4:0]       mem_wr_reg;
    logic [31:0]      mem_alu_result;
    logic             pipe_flush;
    logic             stall;
    logic             branch_taken;
    logic             flush_ifid;
    logic [31:0]      pc_target;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int n_vec;
    int n_miscmp;

    branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_is_branch   (id_is_branch),
        .id_beq         (id_beq),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_target      (id_target),
        .ex_wr_en       (ex_wr_en),
        .ex_is_load     (ex_is_load),
        .ex_wr_reg      (ex_wr_reg),
        .mem_wr_en      (mem_wr_en),
        .mem_is_load    (mem_is_load),
        .mem_wr_reg     (mem_wr_reg),
        .mem_alu_result (mem_alu_result),
        .pipe_flush     (pipe_flush),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .flush_ifid     (flush_ifid),
        .pc_target      (pc_target),
        .taken_cnt      (taken_cnt),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic chk_out(input string tag, input logic exp_stall, input logic exp_taken,
                           input logic [31:0] exp_pc);
        check_val({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
        check_val({tag, ".taken"}, {31'd0, branch_taken}, {31'd0, exp_taken});
        check_val({tag, ".flush"}, {31'd0, flush_ifid}, {31'd0, exp_taken});
        check_val({tag, ".pc"}, pc_target, exp_pc);
    endtask

    task automatic chk_cnt(input string tag, input int exp_taken, input int exp_stall);
        check_val({tag, ".taken_cnt"}, {28'd0, taken_cnt}, exp_taken);
        check_val({tag, ".stall_cnt"}, {28'd0, stall_cnt}, exp_stall);
    endtask

    task automatic clear_in();
        id_valid = 1'b0; id_is_branch = 1'b0; id_beq = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rs_data = 32'd0; id_rt_data = 32'd0;
        id_target = 32'd0;
        ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_reg = 5'd0;
        mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_wr_reg = 5'd0;
        mem_alu_result = 32'd0; pipe_flush = 1'b0;
    endtask

    task automatic set_br(input logic beq, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] tgt);
        clear_in();
        id_valid = 1'b1; id_is_branch = 1'b1; id_beq = beq;
        id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd; id_target = tgt;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_miscmp = 0;
        clear_in();
        rst_n = 1'b0;

        // reset state
        next_cyc();
        @(negedge clk);
        chk_out("rst", 1'b0, 1'b0, 32'd0);
        chk_cnt("rst", 0, 0);
        next_cyc();
        rst_n = 1'b1;

        // beq with no hazard resolves in the same cycle
        set_br(1'b1, 5'd3, 5'd4, 32'h5, 32'h5, 32'h1000);
        @(negedge clk); chk_out("nohaz", 1'b0, 1'b1, 32'h1000);
        next_cyc(); clear_in();
        @(negedge clk); chk_cnt("nohaz", 1, 0);

        // bne, ALU producer of rs in EX: one stall, then forward from MEM
        next_cyc();
        set_br(1'b0, 5'd8, 5'd9, 32'hDEAD, 32'h10, 32'h2000);
        ex_wr_en = 1'b1; ex_wr_reg = 5'd8;
        @(negedge clk); chk_out("alu_c0", 1'b1, 1'b0, 32'd0);
        next_cyc();
        ex_wr_en = 1'b0; mem_wr_en = 1'b1; mem_wr_reg = 5'd8; mem_alu_result = 32'h10;
        @(negedge clk); chk_out("alu_c1", 1'b0, 1'b0, 32'd0);
        next_cyc(); clear_in();
        @(negedge clk); chk_cnt("alu", 1, 1);

        // beq, load producer of rt in EX: two stalls, then taken
        next_cyc();
        set_br(1'b1, 5'd2, 5'd9, 32'h7, 32'h99, 32'h3000);
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_reg = 5'd9;
        @(negedge clk); chk_out("ld_c0", 1'b1, 1'b0, 32'd0);
        next_cyc();
        ex_wr_en = 1'b0; ex_is_load = 1'b0;
        mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_wr_reg = 5'd9;
        @(negedge clk); chk_out("ld_c1", 1'b1, 1'b0, 32'd0);
        next_cyc();
        mem_wr_en = 1'b0; mem_is_load = 1'b0; id_rt_data = 32'h7;
        @(negedge clk); chk_out("ld_c2", 1'b0, 1'b1, 32'h3000);
        next_cyc(); clear_in();
        @(negedge clk); chk_cnt("ld", 2, 3);

        // writes to r0 never hazard
        next_cyc();
        set_br(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4000);
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_reg = 5'd0;
        @(negedge clk); chk_out("r0", 1'b0, 1'b1, 32'h4000);

        // MEM ALU result forwarded without stall (stale rs data would make bne take)
        next_cyc();
        set_br(1'b0, 5'd5, 5'd6, 32'h11, 32'h22, 32'h5000);
        mem_wr_en = 1'b1; mem_wr_reg = 5'd5; mem_alu_result = 32'h22;
        @(negedge clk); chk_out("memfwd", 1'b0, 1'b0, 32'd0);

        // non-branch in ID with a hazard-shaped EX write does nothing
        next_cyc();
        set_br(1'b1, 5'd8, 5'd8, 32'h1, 32'h1, 32'h5500);
        id_is_branch = 1'b0; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_reg = 5'd8;
        @(negedge clk); chk_out("nonbr", 1'b0, 1'b0, 32'd0);
        next_cyc(); clear_in();
        @(negedge clk); chk_cnt("nonbr", 3, 3);

        // pipe_flush in the WAIT cycle aborts the branch
        next_cyc();
        set_br(1'b1, 5'd2, 5'd9, 32'h7, 32'h7, 32'h6000);
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_reg = 5'd9;
        @(negedge clk); chk_out("abort_c0", 1'b1, 1'b0, 32'd0);
        next_cyc();
        ex_wr_en = 1'b0; ex_is_load = 1'b0; pipe_flush = 1'b1;
        @(negedge clk); chk_out("abort_c1", 1'b0, 1'b0, 32'd0);
        next_cyc();
        pipe_flush = 1'b0; id_valid = 1'b0;
        @(negedge clk); chk_out("abort_c2", 1'b0, 1'b0, 32'd0);
        chk_cnt("abort", 3, 4);

        // reset asserted mid-WAIT: no decision afterwards, counters cleared
        next_cyc();
        set_br(1'b1, 5'd2, 5'd9, 32'h7, 32'h7, 32'h6100);
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_reg = 5'd9;
        @(negedge clk); chk_out("rstw_c0", 1'b1, 1'b0, 32'd0);
        next_cyc();
        rst_n = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
        @(negedge clk); chk_out("rstw_c1", 1'b0, 1'b0, 32'd0);
        next_cyc();
        rst_n = 1'b1; id_valid = 1'b0;
        @(negedge clk); chk_out("rstw_c2", 1'b0, 1'b0, 32'd0);
        chk_cnt("rstw", 0, 0);

        // 20 back-to-back taken branches saturate taken_cnt at 4'hF
        next_cyc();
        set_br(1'b1, 5'd1, 5'd2, 32'hA, 32'hA, 32'h7000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) check_val("sat_mid.taken_cnt", {28'd0, taken_cnt}, 32'd10);
            next_cyc();
        end
        clear_in();
        @(negedge clk); chk_cnt("sat_taken", 15, 0);

        // held load hazard: stall, stall, resolve (not taken) repeating; 18 stalls saturate
        next_cyc();
        set_br(1'b1, 5'd1, 5'd2, 32'hA, 32'hB, 32'h7100);
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_reg = 5'd1;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (i == 2) chk_out("sat_res", 1'b0, 1'b0, 32'd0);
            if (i == 3) check_val("sat_mid.stall_cnt", {28'd0, stall_cnt}, 32'd2);
            next_cyc();
        end
        clear_in();
        @(negedge clk); chk_cnt("sat_stall", 15, 15);

        // final reset clears both saturated counters and returns to IDLE
        next_cyc();
        set_br(1'b1, 5'd3, 5'd4, 32'h9, 32'h9, 32'h8000);
        rst_n = 1'b0;
        @(negedge clk); chk_out("rst2_c0", 1'b0, 1'b0, 32'd0);
        next_cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt("rst2", 0, 0);
        chk_out("rst2_c1", 1'b0, 1'b1, 32'h8000);
        next_cyc(); clear_in();
        @(negedge clk); chk_cnt("rst2_after", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
